// File: rtl/uart_tx_fifo_if.sv
// Host write port and UART request handshake of the transmit buffer, bundled
// so the FIFO and its host/UART side share one connection.
interface uart_tx_fifo_if #(
    parameter int AW = 4
);
    logic          iWR;
    logic [7:0]    iWDATA;
    logic          oFULL;
    logic          oEMPTY;
    logic [AW:0]   oCOUNT;
    logic          oOVF;
    logic          oTO;
    logic          oUT;
    logic [7:0]    oUTDATA;
    logic          iUT_DONE;

    modport slave (
        input  iWR, iWDATA, iUT_DONE,
        output oFULL, oEMPTY, oCOUNT, oOVF, oTO, oUT, oUTDATA
    );

    modport master (
        output iWR, iWDATA, iUT_DONE,
        input  oFULL, oEMPTY, oCOUNT, oOVF, oTO, oUT, oUTDATA
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO plus request sequencer: hands one byte at a time to the UART
// and pops it only once the UART reports the frame finished.
module uart_tx_fifo #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 1024
) (
    input logic           iCLK,
    input logic           iRST,
    uart_tx_fifo_if.slave bus
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_BUSY = 2'd2,
        S_GAP  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      mem_q [DEPTH];
    logic [7:0]      mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            ovf_q, ovf_d;
    logic            to_q, to_d;
    logic            ut_q, ut_d;
    logic [7:0]      utdata_q, utdata_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [1:0]      gap_q, gap_d;
    logic            push, pop;

    assign push = bus.iWR & ~full_q;
    assign pop  = (state_q == S_BUSY) & bus.iUT_DONE;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = bus.iWDATA;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!push && pop) begin
            count_d = count_q - (AW+1)'(1);
        end
        full_d  = (count_d == (AW+1)'(DEPTH));
        empty_d = (count_d == '0);
        ovf_d   = bus.iWR & full_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (!empty_q && bus.iUT_DONE) state_d = S_REQ;
            S_REQ: begin
                if (!bus.iUT_DONE) begin
                    state_d = S_BUSY;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_GAP;
                end
            end
            S_BUSY: if (bus.iUT_DONE) state_d = S_GAP;
            S_GAP:  if (gap_q == 2'd2) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Data is loaded on IDLE->REQ and oUT rises one cycle later, so the UART
    // always samples settled data on the request edge. Timeouts also pass
    // through GAP so every oUT low period satisfies the UART synchronizer.
    always_comb begin
        ut_d     = 1'b0;
        utdata_d = utdata_q;
        to_d     = 1'b0;
        timer_d  = timer_q;
        gap_d    = '0;
        case (state_q)
            S_IDLE: begin
                if (state_d == S_REQ) begin
                    utdata_d = mem_q[rd_ptr_q];
                    timer_d  = '0;
                end
            end
            S_REQ: begin
                timer_d = timer_q + TW'(1);
                ut_d    = (state_d == S_REQ);
                to_d    = (state_d == S_GAP);
            end
            S_GAP:   gap_d = gap_q + 2'd1;
            default: ;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            to_q     <= 1'b0;
            ut_q     <= 1'b0;
            utdata_q <= '0;
            timer_q  <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            to_q     <= to_d;
            ut_q     <= ut_d;
            utdata_q <= utdata_d;
            timer_q  <= timer_d;
            gap_q    <= gap_d;
        end
    end

    always_ff @(posedge iCLK) begin
        mem_q <= mem_d;
    end

    assign bus.oFULL   = full_q;
    assign bus.oEMPTY  = empty_q;
    assign bus.oCOUNT  = count_q;
    assign bus.oOVF    = ovf_q;
    assign bus.oTO     = to_q;
    assign bus.oUT     = ut_q;
    assign bus.oUTDATA = utdata_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: fill-level table, handshake corner
// sequences and a randomized run against a queue-based reference.
module tb_uart_tx_fifo;
    localparam int DEPTH   = 16;
    localparam int AW      = 4;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst;

    uart_tx_fifo_if #(.AW(AW)) bus ();

    uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // UART model controls, written only by the main test process
    bit ignore   = 1'b0;
    bit hold     = 1'b0;
    int drop_dly = 4;
    int busy_len = 100;

    // UART model state, written only by the model process
    logic [7:0] sent [$];
    bit         pop_next = 1'b0;

    initial begin : uart_model
        int   ph;
        int   cnt;
        logic ut_prev;
        ph = 0;
        cnt = 0;
        ut_prev = 1'b0;
        bus.iUT_DONE = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            pop_next = 1'b0;
            case (ph)
                0: if (bus.oUT && !ut_prev && !ignore) begin
                    ph  = 1;
                    cnt = drop_dly;
                end
                1: begin
                    cnt--;
                    if (cnt <= 0) begin
                        bus.iUT_DONE = 1'b0;
                        sent.push_back(bus.oUTDATA);
                        ph  = 2;
                        cnt = busy_len;
                    end
                end
                default: if (!hold) begin
                    cnt--;
                    if (cnt <= 0) begin
                        bus.iUT_DONE = 1'b1;
                        pop_next = 1'b1;
                        ph = 0;
                    end
                end
            endcase
            ut_prev = bus.oUT;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d);
        bus.iWR    = 1'b1;
        bus.iWDATA = d;
        @(negedge clk);
        bus.iWR    = 1'b0;
    endtask

    task automatic wait_empty(input string name, input int bound);
        int k = 0;
        while (!bus.oEMPTY && k < bound) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(bus.oEMPTY), 32'd1);
    endtask

    task automatic wait_done(input string name, input logic lvl, input int bound);
        int k = 0;
        while (bus.iUT_DONE !== lvl && k < bound) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(bus.iUT_DONE), 32'(lvl));
    endtask

    typedef struct {
        int n;
        int exp_count;
        bit exp_full;
        bit exp_empty;
        int exp_ovf;
    } vec_t;

    initial begin : main
        vec_t       tbl [6];
        int         base;
        int         k;
        int         ovf_seen;
        logic [7:0] exp_q [$];

        tbl[0] = '{n: 0,  exp_count: 0,  exp_full: 1'b0, exp_empty: 1'b1, exp_ovf: 0};
        tbl[1] = '{n: 1,  exp_count: 1,  exp_full: 1'b0, exp_empty: 1'b0, exp_ovf: 0};
        tbl[2] = '{n: 2,  exp_count: 2,  exp_full: 1'b0, exp_empty: 1'b0, exp_ovf: 0};
        tbl[3] = '{n: 15, exp_count: 15, exp_full: 1'b0, exp_empty: 1'b0, exp_ovf: 0};
        tbl[4] = '{n: 16, exp_count: 16, exp_full: 1'b1, exp_empty: 1'b0, exp_ovf: 0};
        tbl[5] = '{n: 20, exp_count: 16, exp_full: 1'b1, exp_empty: 1'b0, exp_ovf: 4};

        rst        = 1'b1;
        bus.iWR    = 1'b0;
        bus.iWDATA = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_ut",     32'(bus.oUT),     32'd0);
        check("rst_utdata", 32'(bus.oUTDATA), 32'h00);
        check("rst_count",  32'(bus.oCOUNT),  32'd0);
        check("rst_empty",  32'(bus.oEMPTY),  32'd1);
        check("rst_full",   32'(bus.oFULL),   32'd0);
        check("rst_ovf",    32'(bus.oOVF),    32'd0);
        check("rst_to",     32'(bus.oTO),     32'd0);

        // Fill levels with the UART never accepting, so nothing is popped
        ignore = 1'b1;
        for (int t = 0; t < 6; t++) begin
            do_reset();
            ovf_seen = 0;
            for (int i = 0; i < tbl[t].n; i++) begin
                bus.iWR    = 1'b1;
                bus.iWDATA = 8'(i);
                @(negedge clk);
                if (bus.oOVF) ovf_seen++;
            end
            bus.iWR = 1'b0;
            check($sformatf("tbl%0d_count", t), 32'(bus.oCOUNT), 32'(tbl[t].exp_count));
            check($sformatf("tbl%0d_full", t),  32'(bus.oFULL),  32'(tbl[t].exp_full));
            check($sformatf("tbl%0d_empty", t), 32'(bus.oEMPTY), 32'(tbl[t].exp_empty));
            check($sformatf("tbl%0d_ovf", t),   32'(ovf_seen),   32'(tbl[t].exp_ovf));
        end
        ignore = 1'b0;

        // Single byte: request latency, data, and pop one cycle after done
        do_reset();
        drop_dly = 4;
        busy_len = 100;
        base = sent.size();
        write_byte(8'hA5);
        check("t1_count1",   32'(bus.oCOUNT), 32'd1);
        check("t1_ut_w1",    32'(bus.oUT),    32'd0);
        @(negedge clk);
        check("t1_ut_w2",    32'(bus.oUT),    32'd0);
        @(negedge clk);
        check("t1_ut_rise",  32'(bus.oUT),     32'd1);
        check("t1_data",     32'(bus.oUTDATA), 32'hA5);
        wait_done("t1_busy", 1'b0, 20);
        @(negedge clk);
        check("t1_ut_fall",  32'(bus.oUT),     32'd0);
        check("t1_data_hold", 32'(bus.oUTDATA), 32'hA5);
        wait_done("t1_done", 1'b1, 200);
        check("t1_count_pre",  32'(bus.oCOUNT), 32'd1);
        @(negedge clk);
        check("t1_count_post", 32'(bus.oCOUNT), 32'd0);
        check("t1_empty",      32'(bus.oEMPTY), 32'd1);
        check("t1_nsent",      32'(sent.size() - base), 32'd1);
        if (sent.size() > base) check("t1_sent", 32'(sent[base]), 32'hA5);

        // DEPTH+1 back-to-back writes with the UART held busy
        do_reset();
        hold = 1'b1;
        drop_dly = 2;
        busy_len = 10;
        base = sent.size();
        for (int i = 0; i <= DEPTH; i++) begin
            bus.iWR    = 1'b1;
            bus.iWDATA = 8'(i);
            @(negedge clk);
            if (i == DEPTH - 2) check("t2_notfull15", 32'(bus.oFULL), 32'd0);
            if (i == DEPTH - 1) begin
                check("t2_full16",  32'(bus.oFULL),  32'd1);
                check("t2_count16", 32'(bus.oCOUNT), 32'd16);
                check("t2_noovf16", 32'(bus.oOVF),   32'd0);
            end
            if (i == DEPTH) begin
                check("t2_ovf17",   32'(bus.oOVF),   32'd1);
                check("t2_count17", 32'(bus.oCOUNT), 32'd16);
            end
        end
        bus.iWR = 1'b0;
        @(negedge clk);
        check("t2_ovf_pulse", 32'(bus.oOVF), 32'd0);
        hold = 1'b0;
        wait_empty("t2_drain", 1500);
        check("t2_nsent", 32'(sent.size() - base), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            if (base + i < sent.size()) check($sformatf("t2_byte%0d", i), 32'(sent[base + i]), 32'(i));
        end

        // Full FIFO: write coinciding with a pop is dropped, next one lands
        do_reset();
        hold = 1'b1;
        busy_len = 6;
        base = sent.size();
        for (int i = 0; i < DEPTH; i++) write_byte(8'(8'h40 + i));
        wait_done("t3_busy", 1'b0, 20);
        hold = 1'b0;
        wait_done("t3_done", 1'b1, 50);
        bus.iWR    = 1'b1;
        bus.iWDATA = 8'hEE;
        @(negedge clk);
        check("t3_ovf",     32'(bus.oOVF),   32'd1);
        check("t3_count15", 32'(bus.oCOUNT), 32'd15);
        check("t3_notfull", 32'(bus.oFULL),  32'd0);
        bus.iWDATA = 8'hEF;
        @(negedge clk);
        bus.iWR = 1'b0;
        check("t3_count16", 32'(bus.oCOUNT), 32'd16);
        check("t3_full",    32'(bus.oFULL),  32'd1);
        check("t3_noovf",   32'(bus.oOVF),   32'd0);
        wait_empty("t3_drain", 1500);
        check("t3_nsent", 32'(sent.size() - base), 32'(DEPTH + 1));
        for (int i = 0; i < DEPTH; i++) begin
            if (base + i < sent.size()) check($sformatf("t3_byte%0d", i), 32'(sent[base + i]), 32'(8'h40 + i));
        end
        if (base + DEPTH < sent.size()) check("t3_last", 32'(sent[base + DEPTH]), 32'hEF);

        // UART never goes busy: timeout, byte kept, then retransmitted
        do_reset();
        ignore = 1'b1;
        drop_dly = 3;
        busy_len = 12;
        base = sent.size();
        write_byte(8'h77);
        k = 0;
        while (!bus.oUT && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("t4_ut_rise", 32'(bus.oUT), 32'd1);
        k = 0;
        while (!bus.oTO && k < TIMEOUT + 10) begin
            @(negedge clk);
            k++;
        end
        check("t4_to_seen",   32'(bus.oTO), 32'd1);
        check("t4_to_window", 32'(k >= TIMEOUT - 1 && k <= TIMEOUT + 1), 32'd1);
        check("t4_ut_low",    32'(bus.oUT),    32'd0);
        check("t4_count",     32'(bus.oCOUNT), 32'd1);
        @(negedge clk);
        check("t4_to_pulse",  32'(bus.oTO),    32'd0);
        ignore = 1'b0;
        wait_empty("t4_drain", 400);
        check("t4_nsent", 32'(sent.size() - base), 32'd1);
        if (sent.size() > base) check("t4_byte", 32'(sent[base]), 32'h77);

        // Reset while BUSY with 5 bytes queued
        do_reset();
        hold = 1'b1;
        busy_len = 8;
        for (int i = 0; i < 5; i++) write_byte(8'(8'h90 + i));
        wait_done("t5_busy", 1'b0, 20);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_ut",    32'(bus.oUT),    32'd0);
        check("t5_count", 32'(bus.oCOUNT), 32'd0);
        check("t5_empty", 32'(bus.oEMPTY), 32'd1);
        rst = 1'b0;
        base = sent.size();
        hold = 1'b0;
        wait_done("t5_done", 1'b1, 50);
        write_byte(8'h3C);
        wait_empty("t5_drain", 300);
        check("t5_nsent", 32'(sent.size() - base), 32'd1);
        if (sent.size() > base) check("t5_byte", 32'(sent[base]), 32'h3C);

        // Random traffic against a queue + occupancy reference
        do_reset();
        base = sent.size();
        begin
            int   written = 0;
            int   ref_count = 0;
            int   cyc = 0;
            bit   do_wr;
            bit   acc;
            logic [7:0] d;
            while ((written < 40 || ref_count != 0) && cyc < 20000) begin
                drop_dly = $urandom_range(1, 6);
                busy_len = $urandom_range(3, 30);
                do_wr = (written < 40) && ($urandom_range(0, 2) == 0);
                d = 8'($urandom);
                bus.iWR    = do_wr;
                bus.iWDATA = d;
                acc = do_wr && (ref_count < DEPTH);
                if (acc) exp_q.push_back(d);
                ref_count = ref_count + int'(acc) - int'(pop_next);
                @(negedge clk);
                bus.iWR = 1'b0;
                if (do_wr) begin
                    written++;
                    check("t6_ovf", 32'(bus.oOVF), 32'(!acc));
                end
                check("t6_count", 32'(bus.oCOUNT), 32'(ref_count));
                cyc++;
            end
            check("t6_finished", 32'(cyc < 20000), 32'd1);
        end
        check("t6_nsent", 32'(sent.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < sent.size()) check($sformatf("t6_byte%0d", i), 32'(sent[base + i]), 32'(exp_q[i]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
